// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode encodings, fill byte and slave state type
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - pin synchronizer with rise/fall detect against one extra registered copy
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_byte.sv
// rtl/spi_slave_byte.sv - oversampled byte-oriented SPI slave, all four modes, FIFO-style rx/tx
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter logic       CPOL        = 1'b0,
  parameter logic       CPHA        = 1'b0,
  parameter logic [7:0] FILL_BYTE   = FILL_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sclk,
  input  logic       n_cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       tx_empty,
  input  logic [7:0] tx_data,
  output logic       tx_rdreq,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       rx_wrreq,
  input  logic       clr_flags,
  output logic       overrun,
  output logic       underrun,
  output logic       frame_err,
  output logic       ready
);

  localparam logic [1:0] MODE        = {CPOL, CPHA};
  localparam logic       SAMPLE_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

  logic       sclk_rise, sclk_fall, sclk_s;
  logic       cs_s, cs_rise, cs_fall;
  logic       mosi_s;
  logic [1:0] mosi_edge_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .n_rst(n_rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .n_rst(n_rst), .din(n_cs), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .n_rst(n_rst), .din(mosi), .dout(mosi_s),
    .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
  );

  spi_state_t             state_q, state_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_sh;
  logic [6:0]             rx_sh;
  logic                   pend_pop;
  logic [SYNC_STAGES-1:0] settle;
  logic                   armed;
  logic                   frame_start, frame_end, sample_edge, launch_edge, load;
  logic                   set_ovr, set_und, set_ferr;
  logic [7:0]             load_byte;
  logic                   sclk_level_unused;

  assign sclk_level_unused = sclk_s;
  assign load_byte = tx_empty ? FILL_BYTE : tx_data;
  assign ready     = cs_s;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A fall seen before the sync chain has refilled after reset may be a frame already in progress.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample_edge = 1'b0;
    launch_edge = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
          load        = ~CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end else if (!cs_s) begin
          sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
          launch_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;
          load        = launch_edge && (bit_cnt == 3'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign set_und  = sample_edge && (bit_cnt == 3'd0) && !pend_pop;
  assign set_ovr  = sample_edge && (bit_cnt == 3'd7) && rx_full;
  assign set_ferr = frame_end && (bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      tx_rdreq  <= 1'b0;
      rx_wrreq  <= 1'b0;
      rx_data   <= 8'h00;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 7'h00;
      pend_pop  <= 1'b0;
      settle    <= '0;
      armed     <= 1'b0;
    end else begin
      tx_rdreq <= 1'b0;
      rx_wrreq <= 1'b0;
      settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
      if (settle[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
      if (frame_start) miso_oe <= 1'b1;

      if (load) begin
        tx_sh    <= load_byte;
        pend_pop <= !tx_empty;
        miso     <= load_byte[7];
      end else if (launch_edge) begin
        miso <= tx_sh[3'd7 - bit_cnt];
      end

      // The pop is deferred to the first sample so a load the master never clocks costs nothing.
      if (sample_edge) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) begin
          tx_rdreq <= pend_pop;
          pend_pop <= 1'b0;
        end
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_sh, mosi_s};
          rx_wrreq <= !rx_full;
        end
      end

      if (frame_end) begin
        bit_cnt  <= 3'd0;
        miso_oe  <= 1'b0;
        pend_pop <= 1'b0;
      end

      overrun   <= set_ovr  | (overrun   & ~clr_flags);
      underrun  <= set_und  | (underrun  & ~clr_flags);
      frame_err <= set_ferr | (frame_err & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_slave_byte.sv
// tb/tb_spi_slave_byte.sv - directed bench: one slave per SPI mode driven by a behavioural master
module tb_spi_slave_byte;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       mosi;
  logic       rx_full;
  logic       clr_flags;
  logic [3:0] sclk_v;
  logic [3:0] ncs_v;
  logic [3:0] miso_v, oe_v, rdreq_v, wrreq_v, ovr_v, und_v, ferr_v, ready_v, tx_empty_v;
  logic [7:0] tx_data_v [4];
  logic [7:0] rx_data_v [4];

  logic [7:0] tx_mem [4][16];
  logic [7:0] rx_mem [4][16];
  int         tx_head [4] = '{default: 0};
  int         tx_tail [4] = '{default: 0};
  int         rx_n    [4] = '{default: 0};
  int         rd_cnt  [4] = '{default: 0};

  logic [7:0] mtx [2];
  logic [7:0] mrx [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MODE = 2'(g);
    assign tx_empty_v[g] = (tx_head[g] == tx_tail[g]);
    assign tx_data_v[g]  = tx_mem[g][tx_head[g] % 16];
    spi_slave_byte #(.CPOL(MODE[1]), .CPHA(MODE[0]), .FILL_BYTE(8'hFF), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .n_rst(n_rst), .sclk(sclk_v[g]), .n_cs(ncs_v[g]), .mosi(mosi),
      .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_empty(tx_empty_v[g]), .tx_data(tx_data_v[g]),
      .tx_rdreq(rdreq_v[g]), .rx_full(rx_full), .rx_data(rx_data_v[g]), .rx_wrreq(wrreq_v[g]),
      .clr_flags(clr_flags), .overrun(ovr_v[g]), .underrun(und_v[g]), .frame_err(ferr_v[g]),
      .ready(ready_v[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rdreq_v[k]) begin
        tx_head[k] <= tx_head[k] + 1;
        rd_cnt[k]  <= rd_cnt[k] + 1;
      end
      if (wrreq_v[k]) begin
        rx_mem[k][rx_n[k] % 16] <= rx_data_v[k];
        rx_n[k] <= rx_n[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int m, input logic [7:0] b);
    tx_mem[m][tx_tail[m] % 16] = b;
    tx_tail[m] = tx_tail[m] + 1;
  endtask

  // abort_at >= 0 raises n_cs after that many completed bits
  task automatic spi_frame(input int m, input int nbytes, input int abort_at);
    logic cpol, cpha;
    int   k;
    cpol = m[1];
    cpha = m[0];
    k    = 0;
    sclk_v[m] = cpol;
    ncs_v[m]  = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (abort_at >= 0 && k == abort_at) begin
          wait_clk(HALF);
          ncs_v[m] = 1'b1;
          wait_clk(2 * HALF);
          return;
        end
        if (!cpha) begin
          mosi = mtx[b][i];
          wait_clk(HALF);
          sclk_v[m] = ~cpol;
          mrx[b][i] = miso_v[m];
          wait_clk(HALF);
          sclk_v[m] = cpol;
        end else begin
          wait_clk(HALF);
          sclk_v[m] = ~cpol;
          mosi = mtx[b][i];
          wait_clk(HALF);
          sclk_v[m] = cpol;
          mrx[b][i] = miso_v[m];
        end
        k++;
      end
    end
    wait_clk(HALF);
    ncs_v[m] = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, rn0;
    n_rst = 1'b0; mosi = 1'b0; rx_full = 1'b0; clr_flags = 1'b0;
    sclk_v = 4'b1100; ncs_v = 4'hF;
    wait_clk(3);
    check("rst_miso", miso_v[0], 0);
    check("rst_oe", oe_v[0], 0);
    check("rst_rdreq", rdreq_v[0], 0);
    check("rst_wrreq", wrreq_v[0], 0);
    check("rst_rx_data", rx_data_v[0], 8'h00);
    check("rst_flags", {ovr_v[0], und_v[0], ferr_v[0]}, 0);
    check("rst_ready", ready_v[0], 1);
    n_rst = 1'b1;
    wait_clk(10);

    for (int m = 0; m < 4; m++) begin
      push(m, 8'h96); push(m, 8'h0F);
      rd0 = rd_cnt[m]; rn0 = rx_n[m];
      mtx[0] = 8'hA5; mtx[1] = 8'h3C;
      spi_frame(m, 2, -1);
      check($sformatf("m%0d_rx_count", m), rx_n[m] - rn0, 2);
      check($sformatf("m%0d_rx0", m), rx_mem[m][rn0 % 16], 8'hA5);
      check($sformatf("m%0d_rx1", m), rx_mem[m][(rn0 + 1) % 16], 8'h3C);
      check($sformatf("m%0d_miso0", m), mrx[0], 8'h96);
      check($sformatf("m%0d_miso1", m), mrx[1], 8'h0F);
      check($sformatf("m%0d_pops", m), rd_cnt[m] - rd0, 2);
      check($sformatf("m%0d_flags", m), {ovr_v[m], und_v[m], ferr_v[m]}, 0);
      check($sformatf("m%0d_idle", m), {oe_v[m], ready_v[m]}, 2'b01);
    end

    rd0 = rd_cnt[0]; rn0 = rx_n[0];
    mtx[0] = 8'h11;
    spi_frame(0, 1, -1);
    check("und_miso", mrx[0], 8'hFF);
    check("und_flag", und_v[0], 1);
    check("und_pops", rd_cnt[0] - rd0, 0);
    check("und_rx", rx_mem[0][rn0 % 16], 8'h11);
    clr_flags = 1'b1; wait_clk(1); clr_flags = 1'b0; wait_clk(1);
    check("und_clr", und_v[0], 0);

    push(0, 8'h00);
    rn0 = rx_n[0];
    rx_full = 1'b1;
    mtx[0] = 8'h22;
    spi_frame(0, 1, -1);
    rx_full = 1'b0;
    check("ovr_no_push", rx_n[0] - rn0, 0);
    check("ovr_flag", ovr_v[0], 1);
    check("ovr_rx_data", rx_data_v[0], 8'h22);
    check("ovr_no_und", und_v[0], 0);
    push(0, 8'h00);
    mtx[0] = 8'h77;
    spi_frame(0, 1, -1);
    check("ovr_next_push", rx_n[0] - rn0, 1);
    check("ovr_next_rx", rx_mem[0][rn0 % 16], 8'h77);
    check("ovr_sticky", ovr_v[0], 1);
    clr_flags = 1'b1; wait_clk(1); clr_flags = 1'b0; wait_clk(1);
    check("ovr_clr", ovr_v[0], 0);

    rd0 = rd_cnt[0]; rn0 = rx_n[0];
    mtx[0] = 8'h99;
    spi_frame(0, 1, 5);
    check("ferr_flag", ferr_v[0], 1);
    check("ferr_no_push", rx_n[0] - rn0, 0);
    check("ferr_no_pop", rd_cnt[0] - rd0, 0);
    check("ferr_oe", oe_v[0], 0);
    mtx[0] = 8'h5A;
    spi_frame(0, 1, -1);
    check("ferr_next_push", rx_n[0] - rn0, 1);
    check("ferr_next_rx", rx_mem[0][rn0 % 16], 8'h5A);

    push(0, 8'h81);
    rn0 = rx_n[0];
    mtx[0] = 8'hEE;
    fork
      spi_frame(0, 1, -1);
      begin
        wait_clk(20);
        n_rst = 1'b0;
        #1;
        check("mid_rst_miso", miso_v[0], 0);
        check("mid_rst_oe", oe_v[0], 0);
        check("mid_rst_ready", ready_v[0], 1);
        check("mid_rst_flags", {ovr_v[0], und_v[0], ferr_v[0]}, 0);
        wait_clk(2);
        n_rst = 1'b1;
      end
    join
    check("mid_rst_no_push", rx_n[0] - rn0, 0);
    mtx[0] = 8'hC3;
    spi_frame(0, 1, -1);
    check("post_rst_push", rx_n[0] - rn0, 1);
    check("post_rst_rx", rx_mem[0][rn0 % 16], 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte.md
Name: spi_slave_byte

Overview:
- Byte-oriented SPI slave: the far end of the team's SPI master. Fully clk-synchronous; pins are oversampled, not used as clocks.
- Received MOSI bytes are pushed into a "slave->master" FIFO. MISO bytes are taken from a SHOW AHEAD "master->slave" FIFO.
- Supports all four SPI modes and arbitrary-length frames (n_cs low = one frame). MSB first.

Parameters:
- CPOL, 1'b0, sclk idle level.
- CPHA, 1'b0, 0: sample on leading edge; 1: sample on trailing edge.
- FILL_BYTE, 8'hFF, byte sent on MISO when the tx FIFO is empty (underrun).
- SYNC_STAGES, 2, flip-flop stages on sclk/n_cs/mosi (min 2).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low. Clock is clk.
- sclk  in  1  SPI clock from master.
- n_cs  in  1  SPI chip select, active-low.
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master.
- miso_oe  out  1  MISO output enable (tri-state at top level).
- tx_empty  in  1  tx FIFO empty.
- tx_data  in  8  tx FIFO head (show-ahead).
- tx_rdreq  out  1  tx FIFO pop, 1-clk pulse.
- rx_full  in  1  rx FIFO full.
- rx_data  out  8  received byte, valid with rx_wrreq.
- rx_wrreq  out  1  rx FIFO push, 1-clk pulse.
- clr_flags  in  1  clears sticky flags.
- overrun  out  1  sticky: byte dropped because rx_full.
- underrun  out  1  sticky: FILL_BYTE sent because tx_empty.
- frame_err  out  1  sticky: n_cs rose mid-byte.
- ready  out  1  synchronized n_cs high (idle).

Behaviour:
- Reset values:
  - miso = 0, miso_oe = 0, rdreq/wrreq = 0, rx_data = 0.
  - All flags = 0, ready = 1.
  - bit_cnt = 0; sync chains reset to CPOL / 1 / 0.
- Synchronization:
  - sclk, n_cs and mosi each pass SYNC_STAGES FFs; edges are detected against a further registered copy.
  - Pin-to-action latency L = SYNC_STAGES+1 clk.
  - Requirement: sclk high and low times each ≥ SYNC_STAGES+2 clk (met by the team's master with CLK_DIV_EVEN ≥ 8).
- Edge classes:
  - sample edge = rising sclk when CPOL==CPHA, falling otherwise.
  - launch edge = the opposite edge.
  - All sclk edges are ignored while synchronized n_cs is high.
- States:
  - IDLE (n_cs_s high): miso_oe = 0, bit_cnt = 0.
  - ACTIVE: entered on n_cs_s fall; left on n_cs_s rise, back to IDLE the same cycle.
- Byte-start load: on n_cs_s fall when CPHA=0, and on every launch edge with bit_cnt==0.
  - tx_sh <= tx_empty ? FILL_BYTE : tx_data.
  - pend_pop <= !tx_empty.
  - miso <= that byte's bit7.
  - No pop at load time.
- Other launch edges (bit_cnt = k ≠ 0): miso <= tx_sh[7-k]. miso changes only on launch edges or byte-start loads.
- Sample edges:
  - rx_sh <= {rx_sh[6:0], mosi_s}; bit_cnt <= bit_cnt+1 (3-bit wrap).
  - On the first sample edge of a byte:
    - tx_rdreq = pend_pop for one clk, then pend_pop cleared.
    - underrun set if !pend_pop.
  - Consequence: the CPHA=0 trailing launch after the final byte loads a byte but never pops it.
- Eighth sample edge (bit_cnt 7→0): next clk, rx_data <= completed byte.
  - rx_wrreq = !rx_full.
  - If rx_full: byte dropped, overrun set.
- n_cs_s rise:
  - If bit_cnt ≠ 0: partial rx byte discarded, frame_err set; pend_pop cleared with no pop.
  - bit_cnt <= 0, miso_oe <= 0.
- Flags: set has priority over a simultaneous clr_flags.
- n_rst mid-frame: everything returns to reset values immediately. The block resumes at the next n_cs_s fall, never mid-frame.
- At most one rdreq and one wrreq per byte; never both in one clk for the same byte boundary.

Decomposition:
- Package spi_pkg: mode constants (SPI_MODE0..3 as {CPOL,CPHA}) and FILL_DEFAULT.
- One sub-module spi_in_sync: SYNC_STAGES synchronizer plus rise/fall edge detect; instantiated for sclk, n_cs and mosi.

Test Plan:
- Mode 0, master CLK_DIV_EVEN=8, BYTES_PER_FRAME=2, master sends 8'hA5,8'h3C; tx FIFO holds 8'h96,8'h0F.
  - Slave rx FIFO gets A5 then 3C.
  - Master receives 96, 0F.
  - Exactly 2 tx_rdreq and 2 rx_wrreq pulses; flags 0.
- Modes 1, 2 and 3: same traffic repeated with matching master parameters → identical byte results. Exactly 2 pops, so the trailing edge in CPHA=0 does not pop.
- tx FIFO empty, master sends 8'h11 → master receives 8'hFF, underrun=1, no tx_rdreq. clr_flags → underrun=0.
- rx_full=1 during byte 8'h22 → no rx_wrreq, overrun=1, rx FIFO unchanged. Next byte with rx_full=0 → stored normally.
- n_cs forced high after 5 sclk sample edges → frame_err=1, no rx_wrreq, no tx_rdreq. The next full frame 8'h5A is received correctly.
- n_rst asserted mid-byte → miso=0, miso_oe=0, ready=1, flags 0. A subsequent frame sending 8'hC3 is received correctly.
